// File: rtl/wb_stage_q.sv
// ---------------------------------------------------------------------------
// wb_stage_q
// Writeback stage with an in-order retire queue.
//
// Results from the memory stage are accepted over a valid/allowin handshake
// and held in a circular buffer of DEPTH entries.  One entry retires per
// cycle from the head.  Entries that write the register file wait for
// rf_ready.  Entries that do not write it retire without waiting.
//
// Ports
//   clk                in   clock
//   reset              in   asynchronous, active-high reset
//   ws_allowin         out  queue can accept an entry this cycle
//   ms_to_ws_valid     in   memory stage presents an entry
//   ms_to_ws_bus       in   {gr_we, dest, final_res, pc}, MSB first
//   rf_ready           in   register-file write port free this cycle
//   ws_to_rf_bus       out  {rf_we, rf_waddr, rf_wdata}, MSB first
//   ws_retire          out  head entry retires this cycle
//   ws_count           out  number of valid entries held
//   ws_pending_mask    out  bit i set when a queued entry will write reg i
//   debug_wb_pc        out  PC of the head entry (0 when empty)
//   debug_wb_rf_wen    out  {4{rf_we}}
//   debug_wb_rf_wnum   out  dest of the head entry (0 when empty)
//   debug_wb_rf_wdata  out  result of the head entry (0 when empty)
// ---------------------------------------------------------------------------
module wb_stage_q #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int PC_W   = 32,
   parameter int DEPTH  = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   output logic                             ws_allowin,
   input  logic                             ms_to_ws_valid,
   input  logic [1+ADDR_W+DATA_W+PC_W-1:0]  ms_to_ws_bus,
   input  logic                             rf_ready,
   output logic [1+ADDR_W+DATA_W-1:0]       ws_to_rf_bus,
   output logic                             ws_retire,
   output logic [$clog2(DEPTH):0]           ws_count,
   output logic [2**ADDR_W-1:0]             ws_pending_mask,
   output logic [PC_W-1:0]                  debug_wb_pc,
   output logic [3:0]                       debug_wb_rf_wen,
   output logic [ADDR_W-1:0]                debug_wb_rf_wnum,
   output logic [DATA_W-1:0]                debug_wb_rf_wdata
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int MASK_W = 2**ADDR_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

   // Entry storage (intentionally not reset; validity comes from count_q).
   logic              gr_we_q [DEPTH];
   logic [ADDR_W-1:0] dest_q  [DEPTH];
   logic [DATA_W-1:0] res_q   [DEPTH];
   logic [PC_W-1:0]   pc_q    [DEPTH];

   // Queue bookkeeping.
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;

   // Incoming entry fields.
   logic              in_gr_we_s;
   logic [ADDR_W-1:0] in_dest_s;
   logic [DATA_W-1:0] in_res_s;
   logic [PC_W-1:0]   in_pc_s;

   // Handshake and head-of-queue view.
   logic              allowin_s;
   logic              push_s;
   logic              head_valid_s;
   logic              retire_s;
   logic              rf_we_s;
   logic [ADDR_W-1:0] head_dest_s;
   logic [DATA_W-1:0] head_res_s;
   logic [PC_W-1:0]   head_pc_s;
   logic [MASK_W-1:0] mask_s;

   // Split the incoming bus into its fields.
   always_comb begin
      {in_gr_we_s, in_dest_s, in_res_s, in_pc_s} = ms_to_ws_bus;
   end

   // Handshake: allowin depends only on stored state, never on rf_ready.
   always_comb begin
      allowin_s    = (count_q != FULL_CNT);
      push_s       = ms_to_ws_valid && allowin_s;
      head_valid_s = (count_q != ZERO_CNT);
   end

   // Head-entry view: retire/write decisions and zeroed data fields when empty.
   always_comb begin
      retire_s    = 1'b0;
      rf_we_s     = 1'b0;
      head_dest_s = {ADDR_W{1'b0}};
      head_res_s  = {DATA_W{1'b0}};
      head_pc_s   = {PC_W{1'b0}};
      if (head_valid_s) begin
         // A non-writing entry (e.g. a store) does not need the RF port.
         retire_s    = !gr_we_q[rd_ptr_q] || rf_ready;
         rf_we_s     = gr_we_q[rd_ptr_q] && rf_ready;
         head_dest_s = dest_q[rd_ptr_q];
         head_res_s  = res_q[rd_ptr_q];
         head_pc_s   = pc_q[rd_ptr_q];
      end else begin
         retire_s    = 1'b0;
         rf_we_s     = 1'b0;
      end
   end

   // Pending-destination mask built from stored state only, so the head
   // still counts during the cycle in which it retires.
   always_comb begin
      mask_s = {MASK_W{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         // Slot k is valid when its distance from rd_ptr is below count.
         if (({1'b0, PTR_W'(PTR_W'(k) - rd_ptr_q)} < count_q) && gr_we_q[k]) begin
            mask_s[dest_q[k]] = 1'b1;
         end else begin
            mask_s = mask_s;
         end
      end
      // Register 0 is hardwired; never report it as a hazard.
      mask_s[0] = 1'b0;
   end

   // Next-state for pointers and occupancy.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (retire_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, retire_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset empties the queue at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= {PTR_W{1'b0}};
         wr_ptr_q <= {PTR_W{1'b0}};
         count_q  <= ZERO_CNT;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage write on push.
   always_ff @(posedge clk) begin
      if (push_s) begin
         gr_we_q[wr_ptr_q] <= in_gr_we_s;
         dest_q[wr_ptr_q]  <= in_dest_s;
         res_q[wr_ptr_q]   <= in_res_s;
         pc_q[wr_ptr_q]    <= in_pc_s;
      end
   end

   // Output drive.
   always_comb begin
      ws_allowin        = allowin_s;
      ws_retire         = retire_s;
      ws_count          = count_q;
      ws_pending_mask   = mask_s;
      ws_to_rf_bus      = {rf_we_s, head_dest_s, head_res_s};
      debug_wb_pc       = head_pc_s;
      debug_wb_rf_wen   = {4{rf_we_s}};
      debug_wb_rf_wnum  = head_dest_s;
      debug_wb_rf_wdata = head_res_s;
   end

endmodule

// File: tb/tb_wb_stage_q.sv
module tb_wb_stage_q;

   logic         clk;
   logic         reset;
   logic         ws_allowin;
   logic         ms_to_ws_valid;
   logic [69:0]  ms_to_ws_bus;
   logic         rf_ready;
   logic [37:0]  ws_to_rf_bus;
   logic         ws_retire;
   logic [2:0]   ws_count;
   logic [31:0]  ws_pending_mask;
   logic [31:0]  debug_wb_pc;
   logic [3:0]   debug_wb_rf_wen;
   logic [4:0]   debug_wb_rf_wnum;
   logic [31:0]  debug_wb_rf_wdata;

   int errors = 0;
   int checks = 0;

   wb_stage_q #(.DATA_W(32), .ADDR_W(5), .PC_W(32), .DEPTH(4)) dut (
      .clk               (clk),
      .reset             (reset),
      .ws_allowin        (ws_allowin),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .rf_ready          (rf_ready),
      .ws_to_rf_bus      (ws_to_rf_bus),
      .ws_retire         (ws_retire),
      .ws_count          (ws_count),
      .ws_pending_mask   (ws_pending_mask),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic        we;
      logic [4:0]  dest;
      logic [31:0] res;
      logic [31:0] pc;
      logic        rdy;
      logic [2:0]  e_cnt;
      logic        e_allow;
      logic        e_ret;
      logic        e_rfwe;
      logic [4:0]  e_waddr;
      logic [31:0] e_wdata;
      logic [31:0] e_mask;
      logic [31:0] e_pc;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   function automatic vec_t mkv(logic v, logic we, logic [4:0] dest, logic [31:0] res,
                                logic [31:0] pc, logic rdy, logic [2:0] e_cnt, logic e_allow,
                                logic e_ret, logic e_rfwe, logic [4:0] e_waddr,
                                logic [31:0] e_wdata, logic [31:0] e_mask, logic [31:0] e_pc);
      vec_t r;
      r.v = v; r.we = we; r.dest = dest; r.res = res; r.pc = pc; r.rdy = rdy;
      r.e_cnt = e_cnt; r.e_allow = e_allow; r.e_ret = e_ret; r.e_rfwe = e_rfwe;
      r.e_waddr = e_waddr; r.e_wdata = e_wdata; r.e_mask = e_mask; r.e_pc = e_pc;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [4:0] dest,
                        input logic [31:0] res, input logic [31:0] pc, input logic rdy);
      ms_to_ws_valid = v;
      ms_to_ws_bus   = {we, dest, res, pc};
      rf_ready       = rdy;
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_q [$];
   logic [31:0] exp_w;

   initial begin
      // Directed vector table: each row is checked before the edge that applies it.
      vecs[0]  = mkv(1'b0,1'b0,5'd0,32'h0,32'h0,1'b1, 3'd0,1'b1,1'b0,1'b0,5'd0,32'h0,32'h0,32'h0);
      // Test 1: single entry
      vecs[1]  = mkv(1'b1,1'b1,5'd3,32'hDEADBEEF,32'hBFC00000,1'b1, 3'd0,1'b1,1'b0,1'b0,5'd0,32'h0,32'h0,32'h0);
      vecs[2]  = mkv(1'b0,1'b0,5'd0,32'h0,32'h0,1'b1, 3'd1,1'b1,1'b1,1'b1,5'd3,32'hDEADBEEF,32'h8,32'hBFC00000);
      vecs[3]  = mkv(1'b0,1'b0,5'd0,32'h0,32'h0,1'b1, 3'd0,1'b1,1'b0,1'b0,5'd0,32'h0,32'h0,32'h0);
      // Test 2: fill to DEPTH while stalled, extra push rejected, then drain
      vecs[4]  = mkv(1'b1,1'b1,5'd1,32'h11,32'h100,1'b0, 3'd0,1'b1,1'b0,1'b0,5'd0,32'h0,32'h0,32'h0);
      vecs[5]  = mkv(1'b1,1'b1,5'd2,32'h22,32'h104,1'b0, 3'd1,1'b1,1'b0,1'b0,5'd1,32'h11,32'h2,32'h100);
      vecs[6]  = mkv(1'b1,1'b1,5'd3,32'h33,32'h108,1'b0, 3'd2,1'b1,1'b0,1'b0,5'd1,32'h11,32'h6,32'h100);
      vecs[7]  = mkv(1'b1,1'b1,5'd4,32'h44,32'h10C,1'b0, 3'd3,1'b1,1'b0,1'b0,5'd1,32'h11,32'hE,32'h100);
      vecs[8]  = mkv(1'b1,1'b1,5'd5,32'h55,32'h110,1'b0, 3'd4,1'b0,1'b0,1'b0,5'd1,32'h11,32'h1E,32'h100);
      vecs[9]  = mkv(1'b0,1'b0,5'd0,32'h0,32'h0,1'b1, 3'd4,1'b0,1'b1,1'b1,5'd1,32'h11,32'h1E,32'h100);
      vecs[10] = mkv(1'b0,1'b0,5'd0,32'h0,32'h0,1'b1, 3'd3,1'b1,1'b1,1'b1,5'd2,32'h22,32'h1C,32'h104);
      vecs[11] = mkv(1'b0,1'b0,5'd0,32'h0,32'h0,1'b1, 3'd2,1'b1,1'b1,1'b1,5'd3,32'h33,32'h18,32'h108);
      vecs[12] = mkv(1'b0,1'b0,5'd0,32'h0,32'h0,1'b1, 3'd1,1'b1,1'b1,1'b1,5'd4,32'h44,32'h10,32'h10C);
      vecs[13] = mkv(1'b0,1'b0,5'd0,32'h0,32'h0,1'b1, 3'd0,1'b1,1'b0,1'b0,5'd0,32'h0,32'h0,32'h0);
      // Test 3: store at head retires without rf_ready, next entry waits
      vecs[14] = mkv(1'b1,1'b0,5'd7,32'h55,32'h200,1'b0, 3'd0,1'b1,1'b0,1'b0,5'd0,32'h0,32'h0,32'h0);
      vecs[15] = mkv(1'b1,1'b1,5'd8,32'h66,32'h204,1'b0, 3'd1,1'b1,1'b1,1'b0,5'd7,32'h55,32'h0,32'h200);
      vecs[16] = mkv(1'b0,1'b0,5'd0,32'h0,32'h0,1'b0, 3'd1,1'b1,1'b0,1'b0,5'd8,32'h66,32'h100,32'h204);
      vecs[17] = mkv(1'b0,1'b0,5'd0,32'h0,32'h0,1'b0, 3'd1,1'b1,1'b0,1'b0,5'd8,32'h66,32'h100,32'h204);
      vecs[18] = mkv(1'b0,1'b0,5'd0,32'h0,32'h0,1'b1, 3'd1,1'b1,1'b1,1'b1,5'd8,32'h66,32'h100,32'h204);
      vecs[19] = mkv(1'b0,1'b0,5'd0,32'h0,32'h0,1'b1, 3'd0,1'b1,1'b0,1'b0,5'd0,32'h0,32'h0,32'h0);
      // Test 5: dest 0 write still issued, mask bit 0 stays clear
      vecs[20] = mkv(1'b1,1'b1,5'd0,32'h77,32'h300,1'b1, 3'd0,1'b1,1'b0,1'b0,5'd0,32'h0,32'h0,32'h0);
      vecs[21] = mkv(1'b0,1'b0,5'd0,32'h0,32'h0,1'b1, 3'd1,1'b1,1'b1,1'b1,5'd0,32'h77,32'h0,32'h300);
      vecs[22] = mkv(1'b0,1'b0,5'd0,32'h0,32'h0,1'b1, 3'd0,1'b1,1'b0,1'b0,5'd0,32'h0,32'h0,32'h0);

      reset = 1'b1;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      chk("reset_count",   64'(ws_count),        64'd0);
      chk("reset_allowin", 64'(ws_allowin),      64'd1);
      chk("reset_retire",  64'(ws_retire),       64'd0);
      chk("reset_rfwe",    64'(ws_to_rf_bus[37]), 64'd0);
      chk("reset_mask",    64'(ws_pending_mask), 64'd0);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].v, vecs[i].we, vecs[i].dest, vecs[i].res, vecs[i].pc, vecs[i].rdy);
         #2;
         chk($sformatf("v%0d_count", i),   64'(ws_count),             64'(vecs[i].e_cnt));
         chk($sformatf("v%0d_allowin", i), 64'(ws_allowin),           64'(vecs[i].e_allow));
         chk($sformatf("v%0d_retire", i),  64'(ws_retire),            64'(vecs[i].e_ret));
         chk($sformatf("v%0d_rfwe", i),    64'(ws_to_rf_bus[37]),     64'(vecs[i].e_rfwe));
         chk($sformatf("v%0d_waddr", i),   64'(ws_to_rf_bus[36:32]),  64'(vecs[i].e_waddr));
         chk($sformatf("v%0d_wdata", i),   64'(ws_to_rf_bus[31:0]),   64'(vecs[i].e_wdata));
         chk($sformatf("v%0d_mask", i),    64'(ws_pending_mask),      64'(vecs[i].e_mask));
         chk($sformatf("v%0d_pc", i),      64'(debug_wb_pc),          64'(vecs[i].e_pc));
         chk($sformatf("v%0d_wen", i),     64'(debug_wb_rf_wen),      64'({4{vecs[i].e_rfwe}}));
         chk($sformatf("v%0d_wnum", i),    64'(debug_wb_rf_wnum),     64'(vecs[i].e_waddr));
         chk($sformatf("v%0d_dwdata", i),  64'(debug_wb_rf_wdata),    64'(vecs[i].e_wdata));
         next_cycle();
      end

      // Test 4: steady state at count=3, continuous push+retire across pointer wraps
      for (int n = 0; n < 3; n++) begin
         drive(1'b1, 1'b1, 5'(n % 31 + 1), 32'h1000 + 32'(n), 32'(n * 4), 1'b0);
         exp_q.push_back(32'h1000 + 32'(n));
         next_cycle();
      end
      for (int j = 0; j < 20; j++) begin
         drive(1'b1, 1'b1, 5'((j + 3) % 31 + 1), 32'h1000 + 32'(j + 3), 32'((j + 3) * 4), 1'b1);
         #2;
         exp_w = exp_q[0];
         chk($sformatf("s%0d_count", j), 64'(ws_count),           64'd3);
         chk($sformatf("s%0d_rfwe", j),  64'(ws_to_rf_bus[37]),   64'd1);
         chk($sformatf("s%0d_order", j), 64'(ws_to_rf_bus[31:0]), 64'(exp_w));
         void'(exp_q.pop_front());
         exp_q.push_back(32'h1000 + 32'(j + 3));
         next_cycle();
      end
      for (int j = 0; j < 3; j++) begin
         drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
         #2;
         exp_w = exp_q[0];
         chk($sformatf("d%0d_order", j), 64'(ws_to_rf_bus[31:0]), 64'(exp_w));
         void'(exp_q.pop_front());
         next_cycle();
      end
      chk("drain_count", 64'(ws_count), 64'd0);

      // Test 6: reset with 3 entries queued discards them immediately
      for (int n = 1; n <= 3; n++) begin
         drive(1'b1, 1'b1, 5'(n), 32'hA0 + 32'(n), 32'h500 + 32'(n), 1'b0);
         next_cycle();
      end
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
      #1;
      chk("prerst_count", 64'(ws_count),         64'd3);
      chk("prerst_rfwe",  64'(ws_to_rf_bus[37]), 64'd1);
      reset = 1'b1;
      #1;
      chk("rst_count",   64'(ws_count),         64'd0);
      chk("rst_rfwe",    64'(ws_to_rf_bus[37]), 64'd0);
      chk("rst_mask",    64'(ws_pending_mask),  64'd0);
      chk("rst_allowin", 64'(ws_allowin),       64'd1);
      chk("rst_retire",  64'(ws_retire),        64'd0);
      next_cycle();
      reset = 1'b0;
      for (int j = 0; j < 2; j++) begin
         #2;
         chk($sformatf("post%0d_retire", j), 64'(ws_retire),         64'd0);
         chk($sformatf("post%0d_rfwe", j),   64'(ws_to_rf_bus[37]),  64'd0);
         chk($sformatf("post%0d_count", j),  64'(ws_count),          64'd0);
         next_cycle();
      end
      drive(1'b1, 1'b1, 5'd9, 32'hAA, 32'h400, 1'b1);
      next_cycle();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
      #2;
      chk("after_rst_waddr", 64'(ws_to_rf_bus[36:32]), 64'd9);
      chk("after_rst_wdata", 64'(ws_to_rf_bus[31:0]),  64'hAA);
      chk("after_rst_count", 64'(ws_count),            64'd1);
      next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
